cache_axi_arbiter: RTL
======================

Name: cache_axi_arbiter

Overview:
Sits directly upstream of the AXI bridge and is the only agent driving its cache-side request port. It arbitrates among three line-granular requesters: ICache line refill, DCache line refill and DCache dirty-line write-back. It serialises each request into one 8-beat burst on the bridge port. It assembles returned read beats into a full line, and it feeds write-back beats one word per bridge write response.

Parameters:
LINE_WORDS, 8, words per cache line; burst length field = LINE_WORDS-1
DRAIN_CYCLES, 4, idle cycles after the last write beat before another write may start (covers bridge B-channel wait)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ic_rreq  in  1  ICache refill request, level, held until ic_rvalid
ic_raddr  in  32  ICache refill line address, 32-byte aligned
ic_rline  out  32*LINE_WORDS  ICache refill line, word 0 in bits [31:0]
ic_rvalid  out  1  one-cycle pulse, ic_rline valid
dc_rreq  in  1  DCache refill request, level
dc_raddr  in  32  DCache refill line address
dc_rline  out  32*LINE_WORDS  DCache refill line
dc_rvalid  out  1  one-cycle pulse
dc_wreq  in  1  DCache write-back request, level, held until dc_wdone
dc_waddr  in  32  write-back line address
dc_wline  in  32*LINE_WORDS  write-back line, stable while dc_wreq is high
dc_wdone  out  1  one-cycle pulse, write-back accepted
axi_ce_o  out  1  bridge chip enable
axi_ren_o  out  1  bridge read request
axi_wen_o  out  1  bridge write request
axi_raddr_o  out  32  bridge read address
axi_waddr_o  out  32  bridge write address
axi_wdata_o  out  32  current write beat
axi_wsel_o  out  4  byte strobe, constant 4'b1111
axi_rready_o  out  1  high while in RD_REQ/RD_DATA
axi_wvalid_o  out  1  high while in WR_REQ/WR_DATA
axi_wlast_o  out  1  high when beat index = LINE_WORDS-1
axi_rlen_o  out  8  constant LINE_WORDS-1
axi_wlen_o  out  8  constant LINE_WORDS-1
rdata_i  in  32  read beat from bridge
rdata_valid_i  in  1  read beat valid, one pulse per beat
wdata_resp_i  in  1  write beat accepted; present next beat

Behaviour:
- All outputs are registered. Reset (rst=1 at a clk edge): state IDLE, beat counter 0, all outputs 0 except axi_wsel_o=4'b1111 and the len outputs. Reset mid-burst abandons the burst; requesters re-request.
- States: IDLE, RD_REQ, RD_DATA, RD_DONE, WR_REQ, WR_DATA, WR_DRAIN.
- Priority is sampled in IDLE: dc_wreq > dc_rreq > ic_rreq. The grant is fixed until return to IDLE. The granted address and requester id are latched on grant.
- IDLE->WR_REQ on dc_wreq. Cycle after: axi_ce_o=axi_wen_o=1, axi_waddr_o=latched address, axi_wdata_o=word 0, counter=0.
- WR_REQ->WR_DATA after exactly one cycle. ce/wen drop, so exactly one write command is issued.
- WR_DATA: on each wdata_resp_i, counter increments and axi_wdata_o takes word[counter+1]. axi_wlast_o=1 when counter = LINE_WORDS-1.
- wdata_resp_i with counter = LINE_WORDS-1: pulse dc_wdone, go to WR_DRAIN. WR_DRAIN holds DRAIN_CYCLES cycles, then goes to IDLE.
- IDLE->RD_REQ on a read grant. axi_ce_o=axi_ren_o=1, axi_raddr_o=latched address. These stay high until the first rdata_valid_i, so the request is not lost if the bridge is stalled by a same-address write.
- First rdata_valid_i: drop ce/ren, store beat 0, counter=1, go to RD_DATA.
- RD_DATA: each rdata_valid_i stores rdata_i at word[counter] and increments the counter. The beat at counter = LINE_WORDS-1 goes to RD_DONE.
- RD_DONE: for one cycle, drive the granted requester's *_rline with the assembled line and pulse its *_rvalid, then go to IDLE. The non-granted requester's rvalid stays 0.
- rdata_valid_i outside RD_REQ/RD_DATA and wdata_resp_i outside WR_DATA are ignored.
- Requests arriving during a burst wait. A request dropped before grant is not served.
- Counter width is clog2(LINE_WORDS); it never wraps within a burst.

Test Plan:
- Reset with all requests low: all outputs 0, wsel=4'hF, rlen=wlen=8'h07, state IDLE for 10 cycles.
- ic_rreq with ic_raddr=0x1C000020; bridge returns 0xA0..0xA7 with 1-cycle gaps -> ce/ren high until beat 0; one ic_rvalid pulse; ic_rline word k = 0xA0+k; dc_rvalid stays 0.
- dc_wreq, line words 0x100+k, addr 0x00001000; wdata_resp every 2 cycles -> ce/wen high for exactly 1 cycle; wdata sequence 0x100..0x107; wlast only on 0x107; dc_wdone pulse; 4 drain cycles before the next grant.
- dc_wreq, dc_rreq and ic_rreq asserted in the same cycle -> service order write, dc read, ic read. Each completes before the next command is issued.
- Read stall: bridge withholds rdata_valid_i for 20 cycles -> ce/ren held high for all 20 cycles, no second command after beat 0.
- rst=1 asserted at beat 4 of a read -> next cycle IDLE, outputs reset, no rvalid pulse. A re-request after rst=0 completes normally.

Source files
------------

// File: rtl/cache_axi_arbiter_if.sv
// cache_axi_arbiter_if: cache-side request port of the AXI bridge
interface cache_axi_arbiter_if;
  logic        axi_ce_o;
  logic        axi_ren_o;
  logic        axi_wen_o;
  logic [31:0] axi_raddr_o;
  logic [31:0] axi_waddr_o;
  logic [31:0] axi_wdata_o;
  logic [3:0]  axi_wsel_o;
  logic        axi_rready_o;
  logic        axi_wvalid_o;
  logic        axi_wlast_o;
  logic [7:0]  axi_rlen_o;
  logic [7:0]  axi_wlen_o;
  logic [31:0] rdata_i;
  logic        rdata_valid_i;
  logic        wdata_resp_i;
  modport master (
    output axi_ce_o, axi_ren_o, axi_wen_o, axi_raddr_o, axi_waddr_o, axi_wdata_o, axi_wsel_o,
           axi_rready_o, axi_wvalid_o, axi_wlast_o, axi_rlen_o, axi_wlen_o,
    input  rdata_i, rdata_valid_i, wdata_resp_i
  );
  modport slave (
    input  axi_ce_o, axi_ren_o, axi_wen_o, axi_raddr_o, axi_waddr_o, axi_wdata_o, axi_wsel_o,
           axi_rready_o, axi_wvalid_o, axi_wlast_o, axi_rlen_o, axi_wlen_o,
    output rdata_i, rdata_valid_i, wdata_resp_i
  );
endinterface

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: serialises icache/dcache line refills and write-backs into bridge bursts
module cache_axi_arbiter #(
  parameter int LINE_WORDS   = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ic_rreq,
  input  logic [31:0]             ic_raddr,
  output logic [32*LINE_WORDS-1:0] ic_rline,
  output logic                    ic_rvalid,
  input  logic                    dc_rreq,
  input  logic [31:0]             dc_raddr,
  output logic [32*LINE_WORDS-1:0] dc_rline,
  output logic                    dc_rvalid,
  input  logic                    dc_wreq,
  input  logic [31:0]             dc_waddr,
  input  logic [32*LINE_WORDS-1:0] dc_wline,
  output logic                    dc_wdone,
  cache_axi_arbiter_if.master     axi
);
  localparam int CW = $clog2(LINE_WORDS);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, RD_DONE, WR_REQ, WR_DATA, WR_DRAIN} state_t;
  state_t state;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] drn;
  logic gnt_dc;
  logic [32*LINE_WORDS-1:0] line_q, line_n;
  assign axi.axi_wsel_o = 4'b1111;
  assign axi.axi_rlen_o = 8'(LINE_WORDS - 1);
  assign axi.axi_wlen_o = 8'(LINE_WORDS - 1);
  assign cnt_n = cnt + 1'b1;
  always_comb begin
    line_n = line_q;
    line_n[32*cnt +: 32] = axi.rdata_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      drn <= '0;
      gnt_dc <= 1'b0;
      line_q <= '0;
      ic_rline <= '0;
      dc_rline <= '0;
      ic_rvalid <= 1'b0;
      dc_rvalid <= 1'b0;
      dc_wdone <= 1'b0;
      axi.axi_ce_o <= 1'b0;
      axi.axi_ren_o <= 1'b0;
      axi.axi_wen_o <= 1'b0;
      axi.axi_raddr_o <= '0;
      axi.axi_waddr_o <= '0;
      axi.axi_wdata_o <= '0;
      axi.axi_rready_o <= 1'b0;
      axi.axi_wvalid_o <= 1'b0;
      axi.axi_wlast_o <= 1'b0;
    end else begin
      ic_rvalid <= 1'b0;
      dc_rvalid <= 1'b0;
      dc_wdone <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dc_wreq) begin
            state <= WR_REQ;
            axi.axi_ce_o <= 1'b1;
            axi.axi_wen_o <= 1'b1;
            axi.axi_waddr_o <= dc_waddr;
            axi.axi_wdata_o <= dc_wline[31:0];
            axi.axi_wvalid_o <= 1'b1;
            axi.axi_wlast_o <= 1'b0;
          end else if (dc_rreq || ic_rreq) begin
            state <= RD_REQ;
            gnt_dc <= dc_rreq;
            axi.axi_ce_o <= 1'b1;
            axi.axi_ren_o <= 1'b1;
            axi.axi_raddr_o <= dc_rreq ? dc_raddr : ic_raddr;
            axi.axi_rready_o <= 1'b1;
          end
        end
        RD_REQ: if (axi.rdata_valid_i) begin
          state <= RD_DATA;
          axi.axi_ce_o <= 1'b0;
          axi.axi_ren_o <= 1'b0;
          line_q <= line_n;
          cnt <= cnt_n;
        end
        RD_DATA: if (axi.rdata_valid_i) begin
          line_q <= line_n;
          cnt <= cnt == LAST ? '0 : cnt_n;
          if (cnt == LAST) begin
            state <= RD_DONE;
            axi.axi_rready_o <= 1'b0;
            if (gnt_dc) begin
              dc_rline <= line_n;
              dc_rvalid <= 1'b1;
            end else begin
              ic_rline <= line_n;
              ic_rvalid <= 1'b1;
            end
          end
        end
        RD_DONE: state <= IDLE;
        WR_REQ: begin
          state <= WR_DATA;
          axi.axi_ce_o <= 1'b0;
          axi.axi_wen_o <= 1'b0;
        end
        WR_DATA: if (axi.wdata_resp_i) begin
          if (cnt == LAST) begin
            state <= WR_DRAIN;
            dc_wdone <= 1'b1;
            axi.axi_wvalid_o <= 1'b0;
            axi.axi_wlast_o <= 1'b0;
            cnt <= '0;
            drn <= '0;
          end else begin
            cnt <= cnt_n;
            axi.axi_wdata_o <= dc_wline[32*cnt_n +: 32];
            axi.axi_wlast_o <= cnt_n == LAST;
          end
        end
        WR_DRAIN: begin
          state <= drn == DW'(DRAIN_CYCLES - 1) ? IDLE : WR_DRAIN;
          drn <= drn + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
